prescaled_updown_counter: RTL and testbench



---
 rtl/prescaled_counter_pkg.sv | 34 +++
 rtl/prescaled_updown_counter_prescale_tick_gen.sv | 57 +++++
 rtl/prescaled_updown_counter.sv | 115 +++++++++++
 tb/tb_prescaled_updown_counter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaled_counter_pkg.sv
// -----------------------------------------------------------------------------
// prescaled_counter_pkg
// Shared definitions for the prescaled up/down counter:
//   - default widths for counter, prescaler and LED output
//   - max_value(): all-ones value for a given bit width
//   - step_e: encoding of what a counter step does on a tick
// -----------------------------------------------------------------------------
package prescaled_counter_pkg;

  localparam int DEF_CNT_WIDTH      = 12;
  localparam int DEF_PRESCALE_WIDTH = 25;
  localparam int DEF_OUT_WIDTH      = 8;

  // Outcome of a tick for the counter register.
  //   STEP_HOLD : keep value (no tick, or saturated at a bound)
  //   STEP_INC  : count + 1
  //   STEP_DEC  : count - 1
  //   STEP_WRAP : crossed a bound in wrap mode (up -> 0, down -> MAX)
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_WRAP = 2'd3
  } step_e;

  // All-ones value of a 'width'-bit unsigned number (width <= 64).
  function automatic logic [63:0] max_value(input int unsigned width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/prescaled_updown_counter_prescale_tick_gen.sv
// -----------------------------------------------------------------------------
// prescale_tick_gen
// Runtime-programmable prescaler. Counts enabled cycles and raises the
// internal strobe s when the count has reached div; tick is s registered.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   en       in   advance enable; en=0 freezes the prescaler and blocks s
//   clear    in   synchronous clear of prescaler and tick
//   div      in   divisor; one strobe every div+1 enabled cycles
//   s        out  combinational strobe (terminal reached on an enabled cycle)
//   tick     out  registered strobe, high the cycle after s
// -----------------------------------------------------------------------------
module prescale_tick_gen
  import prescaled_counter_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] div,
  output logic                      s,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic                      r_tick;
  logic                      w_s;

  // >= rather than == so that lowering div below the current count
  // terminates on the next enabled cycle instead of running the
  // prescaler all the way round.
  assign w_s = en && (r_presc >= div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (clear) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_s;
      if (w_s) begin
        r_presc <= '0;
      end else if (en) begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign s    = w_s;
  assign tick = r_tick;

endmodule

// File: rtl/prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// prescaled_updown_counter
// Prescaled up/down counter for the on-board LEDs. Each prescaler strobe
// steps the counter up or down, wrapping or saturating at the bounds.
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   en          in   prescaler advance enable
//   clear       in   synchronous clear of prescaler and counter (top priority)
//   down        in   0 = up, 1 = down; sampled on the stepping edge
//   sat         in   0 = wrap, 1 = saturate; sampled on the stepping edge
//   load        in   synchronous load of load_value (discards that step)
//   load_value  in   value to load
//   div         in   prescale divisor; tick period is div+1 enabled cycles
//   count       out  counter register
//   LED         out  low OUT_WIDTH bits of count
//   tick        out  registered one-cycle prescaler pulse
//   tc          out  registered pulse when a step hit or wrapped a bound
// -----------------------------------------------------------------------------
module prescaled_updown_counter
  import prescaled_counter_pkg::*;
#(
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      down,
  input  logic                      sat,
  input  logic                      load,
  input  logic [CNT_WIDTH-1:0]      load_value,
  input  logic [PRESCALE_WIDTH-1:0] div,
  output logic [CNT_WIDTH-1:0]      count,
  output logic [OUT_WIDTH-1:0]      LED,
  output logic                      tick,
  output logic                      tc
);

  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(max_value(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_tc;
  logic                 w_s;
  logic                 w_tick;
  step_e                w_step;
  logic                 w_hit;

  prescale_tick_gen #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clear   (clear),
    .div     (div),
    .s       (w_s),
    .tick    (w_tick)
  );

  // Decide what this strobe does to the counter. w_hit flags that the
  // step started at the bound in the current direction; it drives tc in
  // both wrap and saturate modes.
  always_comb begin
    w_step = STEP_HOLD;
    w_hit  = 1'b0;
    if (w_s) begin
      if (!down) begin
        if (r_count == MAX) begin
          w_hit  = 1'b1;
          w_step = sat ? STEP_HOLD : STEP_WRAP;
        end else begin
          w_step = STEP_INC;
        end
      end else begin
        if (r_count == '0) begin
          w_hit  = 1'b1;
          w_step = sat ? STEP_HOLD : STEP_WRAP;
        end else begin
          w_step = STEP_DEC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      // Prescaler keeps running (tick still fires) but this step is dropped.
      r_count <= load_value;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= w_hit;
      case (w_step)
        STEP_INC:  r_count <= r_count + 1'b1;
        STEP_DEC:  r_count <= r_count - 1'b1;
        STEP_WRAP: r_count <= down ? MAX : '0;
        default:   r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign LED   = r_count[OUT_WIDTH-1:0];
  assign tick  = w_tick;
  assign tc    = r_tc;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
module tb_prescaled_updown_counter;

  localparam int CW   = 12;
  localparam int PW   = 25;
  localparam int OW   = 8;
  localparam int MAXV = 4095;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          en, clear, down, sat, load;
  logic [CW-1:0] load_value;
  logic [PW-1:0] div;
  logic [CW-1:0] count;
  logic [OW-1:0] LED;
  logic          tick, tc;

  always #5 clk = ~clk;

  prescaled_updown_counter #(
    .CNT_WIDTH      (CW),
    .PRESCALE_WIDTH (PW),
    .OUT_WIDTH      (OW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .clear      (clear),
    .down       (down),
    .sat        (sat),
    .load       (load),
    .load_value (load_value),
    .div        (div),
    .count      (count),
    .LED        (LED),
    .tick       (tick),
    .tc         (tc)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Enabled-cycle counter since the last terminal, plus integer counter.
  int m_presc;
  int m_count;
  int m_tick;
  int m_tc;

  // scoreboard: {count, tick, tc} expected after each edge
  logic [CW+1:0] exp_q[$];

  function automatic void model_reset();
    m_presc = 0;
    m_count = 0;
    m_tick  = 0;
    m_tc    = 0;
  endfunction

  function automatic void model_step();
    int s;
    int nxt;
    s = (en && (m_presc >= int'(div))) ? 1 : 0;
    if (clear) begin
      m_presc = 0;
      m_count = 0;
      m_tick  = 0;
      m_tc    = 0;
    end else begin
      m_tick  = s;
      m_presc = s ? 0 : (en ? m_presc + 1 : m_presc);
      if (load) begin
        m_count = int'(load_value);
        m_tc    = 0;
      end else if (s != 0) begin
        if (!down) begin
          m_tc = (m_count == MAXV) ? 1 : 0;
          nxt  = m_count + 1;
          if (nxt > MAXV) nxt = sat ? MAXV : 0;
        end else begin
          m_tc = (m_count == 0) ? 1 : 0;
          nxt  = (m_count == 0) ? (sat ? 0 : MAXV) : m_count - 1;
        end
        m_count = nxt;
      end else begin
        m_tc = 0;
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit clr, input bit ld, input int lv, input bit dn,
                        input bit st, input bit e, input int d);
    clear      = clr;
    load       = ld;
    load_value = CW'(lv);
    down       = dn;
    sat        = st;
    en         = e;
    div        = PW'(d);
  endtask

  // One clock: predict, clock, compare DUT against the scoreboard entry.
  task automatic cycle();
    logic [CW+1:0] e;
    model_step();
    exp_q.push_back({m_count[CW-1:0], m_tick[0], m_tc[0]});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("mdl_count", int'(count), int'(e[CW+1:2]));
    check("mdl_led",   int'(LED),   int'(e[OW+1:2]));
    check("mdl_tick",  int'(tick),  int'(e[1]));
    check("mdl_tc",    int'(tc),    int'(e[0]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit clr;
    bit ld;
    int lv;
    bit dn;
    bit st;
    bit e;
    int d;
    int ec;
    bit et;
    bit etc;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(bit clr, bit ld, int lv, bit dn, bit st, bit e,
                              int d, int ec, bit et, bit etc);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.dn = dn; v.st = st;
    v.e = e; v.d = d; v.ec = ec; v.et = et; v.etc = etc;
    return v;
  endfunction

  initial begin
    //             clr ld lv     dn st en div  count  tick tc
    vecs[0]  = mk(1, 0, 0,     0, 0, 1, 0,   'h000, 0, 0);
    vecs[1]  = mk(0, 1, 'hFFE, 0, 0, 1, 0,   'hFFE, 1, 0);
    vecs[2]  = mk(0, 0, 0,     0, 0, 1, 0,   'hFFF, 1, 0);
    vecs[3]  = mk(0, 0, 0,     0, 0, 1, 0,   'h000, 1, 1);
    vecs[4]  = mk(0, 0, 0,     0, 0, 1, 0,   'h001, 1, 0);
    vecs[5]  = mk(0, 1, 'hFFE, 0, 1, 1, 0,   'hFFE, 1, 0);
    vecs[6]  = mk(0, 0, 0,     0, 1, 1, 0,   'hFFF, 1, 0);
    vecs[7]  = mk(0, 0, 0,     0, 1, 1, 0,   'hFFF, 1, 1);
    vecs[8]  = mk(0, 0, 0,     0, 1, 1, 0,   'hFFF, 1, 1);
    vecs[9]  = mk(0, 1, 'h002, 1, 0, 1, 0,   'h002, 1, 0);
    vecs[10] = mk(0, 0, 0,     1, 0, 1, 0,   'h001, 1, 0);
    vecs[11] = mk(0, 0, 0,     1, 0, 1, 0,   'h000, 1, 0);
    vecs[12] = mk(0, 0, 0,     1, 0, 1, 0,   'hFFF, 1, 1);
    vecs[13] = mk(0, 1, 'h001, 1, 1, 1, 0,   'h001, 1, 0);
    vecs[14] = mk(0, 0, 0,     1, 1, 1, 0,   'h000, 1, 0);
    vecs[15] = mk(0, 0, 0,     1, 1, 1, 0,   'h000, 1, 1);
    vecs[16] = mk(0, 0, 0,     1, 1, 1, 0,   'h000, 1, 1);
    vecs[17] = mk(1, 1, 'hABC, 0, 0, 1, 0,   'h000, 0, 0);
    vecs[18] = mk(0, 1, 'h123, 0, 0, 1, 0,   'h123, 1, 0);
    vecs[19] = mk(0, 0, 0,     0, 0, 1, 0,   'h124, 1, 0);
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int lv_pick;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("por_count", int'(count), 0);
    check("por_led",   int'(LED),   0);
    check("por_tick",  int'(tick),  0);
    check("por_tc",    int'(tc),    0);
    reset_n = 1'b1;

    // wrap / saturate / down / priority table
    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].dn, vecs[i].st,
             vecs[i].e, vecs[i].d);
      cycle();
      check($sformatf("tbl%0d_count", i), int'(count), vecs[i].ec);
      check($sformatf("tbl%0d_led", i),   int'(LED),   vecs[i].ec & 'hFF);
      check($sformatf("tbl%0d_tick", i),  int'(tick),  int'(vecs[i].et));
      check($sformatf("tbl%0d_tc", i),    int'(tc),    int'(vecs[i].etc));
    end

    // asynchronous reset mid-cycle, no clock edge needed
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", int'(count), 0);
    check("arst_led",   int'(LED),   0);
    check("arst_tick",  int'(tick),  0);
    check("arst_tc",    int'(tc),    0);

    // free run from reset, div=3: tick every 4 clocks
    set_in(0, 0, 0, 0, 0, 1, 3);
    #3;
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check("free_count", int'(count), k / 4);
      check("free_tick",  int'(tick),  (k % 4 == 0) ? 1 : 0);
    end

    // divisor lowered below the running prescale count
    set_in(1, 0, 0, 0, 0, 1, 10);
    cycle();
    set_in(0, 0, 0, 0, 0, 1, 10);
    for (int k = 0; k < 7; k++) begin
      cycle();
      check("div10_tick", int'(tick), 0);
    end
    div = PW'(2);
    for (int j = 0; j < 7; j++) begin
      cycle();
      check("div2_tick", int'(tick), (j % 3 == 0) ? 1 : 0);
    end

    // enable gating, div=4, en alternating
    set_in(1, 0, 0, 0, 0, 1, 4);
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0);
      cycle();
      check("gate_tick",  int'(tick),  (i == 8 || i == 18) ? 1 : 0);
      check("gate_count", int'(count), ((i >= 8) ? 1 : 0) + ((i >= 18) ? 1 : 0));
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 31) == 0);
      load  = ($urandom_range(0, 15) == 0);
      lv_pick = $urandom_range(0, 4);
      case (lv_pick)
        0:       load_value = CW'(0);
        1:       load_value = CW'(1);
        2:       load_value = CW'(MAXV - 1);
        3:       load_value = CW'(MAXV);
        default: load_value = CW'($urandom_range(0, MAXV));
      endcase
      down = $urandom_range(0, 1) == 1;
      sat  = $urandom_range(0, 1) == 1;
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) div = PW'($urandom_range(0, 4));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
